// File: rtl/sndgen_envctl.sv
`default_nettype none
// ============================================================================
// Module   : sndgen_envctl
// Purpose  : Envelope scheduler and register-port arbiter sitting in front of
//            a 32-voice sound generator.
//            - CPU writes with addr[7]=0 are registered and forwarded to the
//              generator one cycle later.
//            - CPU writes with addr[7]=1 configure the per-voice peak and rate
//              tables and the 32-bit gate register.
//            - Once per envelope tick an engine sweeps all 32 voices. For each
//              voice it advances the attack/sustain/release envelope and
//              writes the scaled L/R amplitude into the generator's amp
//              register. The CPU passthrough always wins the shared port.
// Ports    : clk       system clock
//            reset     asynchronous active-low reset
//            cs/we/addr/din              CPU write port
//            snd_cs/snd_we/snd_addr/snd_din  generator register port
//            busy      sweep in progress
//            overrun   sticky: a tick arrived while a sweep was still running
// Revision : 1.0  initial release
// ============================================================================
module sndgen_envctl #(
    parameter int TICK_DIV = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    output logic        snd_cs,
    output logic [3:0]  snd_we,
    output logic [7:0]  snd_addr,
    output logic [31:0] snd_din,
    output logic        busy,
    output logic        overrun
);

    localparam int                 c_cnt_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_max = c_cnt_w'(TICK_DIV - 1);
    localparam logic [4:0]         c_last_v   = 5'd31;

    // Per-voice envelope state encoding
    localparam logic [1:0] c_env_idle    = 2'd0;
    localparam logic [1:0] c_env_attack  = 2'd1;
    localparam logic [1:0] c_env_sustain = 2'd2;
    localparam logic [1:0] c_env_release = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CALC  = 2'd2,
        S_ISSUE = 2'd3
    } eng_state_t;

    // Byte-enable merge used by all CPU-writable registers
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // CPU decode
    // ------------------------------------------------------------------
    logic       w_cpu_pt;
    logic       w_wr_peak;
    logic       w_wr_rate;
    logic       w_wr_gate;
    logic [4:0] w_vsel;

    assign w_cpu_pt  = cs && !addr[7];
    assign w_wr_peak = cs && (addr[7:5] == 3'b100);
    assign w_wr_rate = cs && (addr[7:5] == 3'b101);
    assign w_wr_gate = cs && (addr == 8'hC0);
    assign w_vsel    = addr[4:0];

    // ------------------------------------------------------------------
    // Tick counter
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_tick_cnt;
    logic               w_tick;

    assign w_tick = (r_tick_cnt == c_tick_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered CPU passthrough
    // ------------------------------------------------------------------
    logic        r_pt_valid;
    logic [3:0]  r_pt_we;
    logic [7:0]  r_pt_addr;
    logic [31:0] r_pt_din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pt_valid <= 1'b0;
            r_pt_we    <= '0;
            r_pt_addr  <= '0;
            r_pt_din   <= '0;
        end else begin
            r_pt_valid <= w_cpu_pt;
            if (w_cpu_pt) begin
                r_pt_we   <= we;
                r_pt_addr <= addr;
                r_pt_din  <= din;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration storage. Peak/rate tables are plain RAM without reset.
    // ------------------------------------------------------------------
    logic [31:0] r_peak [32];
    logic [31:0] r_rate [32];
    logic [31:0] r_gate;

    always_ff @(posedge clk) begin
        if (w_wr_peak) begin
            r_peak[w_vsel] <= f_merge(r_peak[w_vsel], din, we);
        end
        if (w_wr_rate) begin
            r_rate[w_vsel] <= f_merge(r_rate[w_vsel], din, we);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gate <= '0;
        end else if (w_wr_gate) begin
            r_gate <= f_merge(r_gate, din, we);
        end
    end

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    eng_state_t r_state;
    eng_state_t w_state_nxt;
    logic [4:0] r_voice;
    logic       w_grant;

    // The port belongs to the engine only when the passthrough register is empty
    assign w_grant = (r_state == S_ISSUE) && !r_pt_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_grant) begin
                    w_state_nxt = (r_voice == c_last_v) ? S_IDLE : S_READ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Envelope step for the voice fetched in READ
    // ------------------------------------------------------------------
    logic [1:0]  r_cur_env;
    logic [15:0] r_cur_level;
    logic [31:0] r_cur_peak;
    logic [31:0] r_cur_rate;
    logic        r_cur_gate;

    logic [1:0]  w_env_sel;
    logic [1:0]  w_env_nxt;
    logic [15:0] w_level_nxt;
    logic [16:0] w_atk_sum;
    logic [16:0] w_rel_diff;
    logic [15:0] w_atk;
    logic [15:0] w_rel;

    assign w_atk      = r_cur_rate[15:0];
    assign w_rel      = r_cur_rate[31:16];
    assign w_atk_sum  = {1'b0, r_cur_level} + {1'b0, w_atk};
    // Bit 16 of the difference is the borrow, i.e. the level would go negative
    assign w_rel_diff = {1'b0, r_cur_level} - {1'b0, w_rel};

    always_comb begin
        // Gate-driven transition first; the arithmetic of the resulting state
        // is then applied to the pre-step level in the same sweep.
        w_env_sel = r_cur_env;
        if (((r_cur_env == c_env_idle) || (r_cur_env == c_env_release)) && r_cur_gate) begin
            w_env_sel = c_env_attack;
        end else if (((r_cur_env == c_env_attack) || (r_cur_env == c_env_sustain)) && !r_cur_gate) begin
            w_env_sel = c_env_release;
        end

        w_env_nxt   = w_env_sel;
        w_level_nxt = r_cur_level;
        case (w_env_sel)
            c_env_attack: begin
                if ((w_atk == 16'h0000) || w_atk_sum[16] || (w_atk_sum[15:0] == 16'hFFFF)) begin
                    w_level_nxt = 16'hFFFF;
                    w_env_nxt   = c_env_sustain;
                end else begin
                    w_level_nxt = w_atk_sum[15:0];
                end
            end
            c_env_release: begin
                if ((w_rel == 16'h0000) || w_rel_diff[16] || (w_rel_diff[15:0] == 16'h0000)) begin
                    w_level_nxt = 16'h0000;
                    w_env_nxt   = c_env_idle;
                end else begin
                    w_level_nxt = w_rel_diff[15:0];
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Amplitude scaling. Full level maps to 0x10000 so that SUSTAIN yields
    // exactly the peak. The product of a signed 16-bit peak and a 17-bit
    // level never exceeds 32 signed bits, so a 32-bit product is exact.
    // ------------------------------------------------------------------
    logic [16:0] w_lprime;
    logic [31:0] w_lp_ext;
    logic [31:0] w_pk_l;
    logic [31:0] w_pk_r;
    logic [31:0] w_prod_l;
    logic [31:0] w_prod_r;
    logic [15:0] w_amp_l;
    logic [15:0] w_amp_r;

    assign w_lprime = (w_level_nxt == 16'hFFFF) ? 17'h10000 : {1'b0, w_level_nxt};
    assign w_lp_ext = {15'b0, w_lprime};
    assign w_pk_l   = {{16{r_cur_peak[15]}}, r_cur_peak[15:0]};
    assign w_pk_r   = {{16{r_cur_peak[31]}}, r_cur_peak[31:16]};
    assign w_prod_l = w_pk_l * w_lp_ext;
    assign w_prod_r = w_pk_r * w_lp_ext;
    assign w_amp_l  = 16'(w_prod_l >> 16);
    assign w_amp_r  = 16'(w_prod_r >> 16);

    // ------------------------------------------------------------------
    // Engine datapath and per-voice envelope state
    // ------------------------------------------------------------------
    logic [1:0]  r_vstate [32];
    logic [15:0] r_level  [32];
    logic [15:0] r_amp_l;
    logic [15:0] r_amp_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_voice     <= '0;
            r_cur_env   <= c_env_idle;
            r_cur_level <= '0;
            r_cur_peak  <= '0;
            r_cur_rate  <= '0;
            r_cur_gate  <= 1'b0;
            r_amp_l     <= '0;
            r_amp_r     <= '0;
            for (int i = 0; i < 32; i++) begin
                r_vstate[i] <= c_env_idle;
                r_level[i]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_voice <= '0;
                    end
                end
                S_READ: begin
                    // Snapshot everything for this voice; later config writes
                    // to it are seen on the next sweep.
                    r_cur_env   <= r_vstate[r_voice];
                    r_cur_level <= r_level[r_voice];
                    r_cur_peak  <= r_peak[r_voice];
                    r_cur_rate  <= r_rate[r_voice];
                    r_cur_gate  <= r_gate[r_voice];
                end
                S_CALC: begin
                    r_vstate[r_voice] <= w_env_nxt;
                    r_level[r_voice]  <= w_level_nxt;
                    r_amp_l           <= w_amp_l;
                    r_amp_r           <= w_amp_r;
                end
                S_ISSUE: begin
                    if (w_grant) begin
                        r_voice <= r_voice + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Generator port mux: passthrough first, engine request otherwise
    // ------------------------------------------------------------------
    always_comb begin
        snd_cs   = 1'b0;
        snd_we   = 4'h0;
        snd_addr = 8'h00;
        snd_din  = 32'h0;
        if (r_pt_valid) begin
            snd_cs   = 1'b1;
            snd_we   = r_pt_we;
            snd_addr = r_pt_addr;
            snd_din  = r_pt_din;
        end else if (r_state == S_ISSUE) begin
            snd_cs   = 1'b1;
            snd_we   = 4'hF;
            snd_addr = {3'b010, r_voice};
            snd_din  = {r_amp_r, r_amp_l};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sndgen_envctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sndgen_envctl
// Purpose  : Self-checking bench for sndgen_envctl. A transaction-level model
//            tracks passthrough writes, sweep progress and per-voice
//            envelopes; a negedge compare process checks every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_sndgen_envctl;

    localparam int TICK_DIV = 256;

    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_SUS  = 2;
    localparam int M_REL  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] din = 32'h0;
    logic        snd_cs;
    logic [3:0]  snd_we;
    logic [7:0]  snd_addr;
    logic [31:0] snd_din;
    logic        busy;
    logic        overrun;

    sndgen_envctl #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .snd_cs   (snd_cs),
        .snd_we   (snd_we),
        .snd_addr (snd_addr),
        .snd_din  (snd_din),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int          m_state [32];
    int          m_level [32];
    logic [31:0] m_peak  [32];
    logic [31:0] m_rate  [32];
    logic [31:0] m_gate;
    bit          m_busy, m_ovr, m_pt;
    logic [3:0]  m_pt_we;
    logic [7:0]  m_pt_addr;
    logic [31:0] m_pt_din;
    int          m_cnt, m_voice, m_idx;
    int          cyc, sweep_start;
    int          v_wr_cnt [32];
    int          v_wr_cyc [32];
    logic [31:0] last_din [32];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Advances voice v by one envelope step and returns {ampR, ampL}
    function automatic logic [31:0] model_voice(input int v);
        int st, lv, atk, rel;
        bit g;
        longint pl, pr, lp;
        st  = m_state[v];
        lv  = m_level[v];
        g   = m_gate[v];
        atk = int'(m_rate[v][15:0]);
        rel = int'(m_rate[v][31:16]);
        if ((st == M_IDLE || st == M_REL) && g) st = M_ATK;
        else if ((st == M_ATK || st == M_SUS) && !g) st = M_REL;
        if (st == M_ATK) begin
            lv = (atk == 0) ? 65535 : lv + atk;
            if (lv >= 65535) begin lv = 65535; st = M_SUS; end
        end else if (st == M_REL) begin
            lv = (rel == 0) ? 0 : lv - rel;
            if (lv <= 0) begin lv = 0; st = M_IDLE; end
        end
        m_state[v] = st;
        m_level[v] = lv;
        lp = (lv == 65535) ? 64'sd65536 : longint'(lv);
        pl = longint'($signed(m_peak[v][15:0]));
        pr = longint'($signed(m_peak[v][31:16]));
        return {16'((pr * lp) >>> 16), 16'((pl * lp) >>> 16)};
    endfunction

    bit          due, tick, busy_b;
    logic [31:0] exp_din;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_snd_cs", {31'b0, snd_cs}, 32'h0);
            check("rst_snd_bus", {20'b0, snd_we, snd_addr} | snd_din, 32'h0);
            check("rst_busy", {31'b0, busy}, 32'h0);
            check("rst_overrun", {31'b0, overrun}, 32'h0);
            for (int i = 0; i < 32; i++) begin m_state[i] = M_IDLE; m_level[i] = 0; end
            m_gate = '0; m_busy = 0; m_ovr = 0; m_pt = 0;
            m_cnt = 0; m_voice = 0; m_idx = 0;
        end else begin
            cyc++;
            due = m_busy && (m_idx >= 2) && !m_pt;
            check("snd_cs", {31'b0, snd_cs}, {31'b0, m_pt | due});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            if (m_pt) begin
                check("pt_addr", {24'b0, snd_addr}, {24'b0, m_pt_addr});
                check("pt_we", {28'b0, snd_we}, {28'b0, m_pt_we});
                check("pt_din", snd_din, m_pt_din);
            end else if (due) begin
                exp_din = model_voice(m_voice);
                check("eng_addr", {24'b0, snd_addr}, 32'h40 + 32'(m_voice));
                check("eng_we", {28'b0, snd_we}, 32'hF);
                check("eng_din", snd_din, exp_din);
                v_wr_cnt[m_voice]++;
                v_wr_cyc[m_voice] = cyc - sweep_start;
                last_din[m_voice] = snd_din;
            end
            // Effects of the coming rising edge
            tick   = (m_cnt == TICK_DIV - 1);
            m_cnt  = tick ? 0 : m_cnt + 1;
            busy_b = m_busy;
            if (tick && busy_b) m_ovr = 1;
            if (due) begin
                if (m_voice == 31) m_busy = 0;
                else begin m_voice++; m_idx = 0; end
            end else if (m_busy) begin
                m_idx++;
            end
            if (tick && !busy_b) begin
                m_busy = 1; m_voice = 0; m_idx = 0; sweep_start = cyc + 1;
                for (int i = 0; i < 32; i++) v_wr_cnt[i] = 0;
            end
            m_pt = cs && !addr[7];
            m_pt_we = we; m_pt_addr = addr; m_pt_din = din;
            if (cs && addr[7:5] == 3'b100) m_peak[addr[4:0]] = merge(m_peak[addr[4:0]], din, we);
            if (cs && addr[7:5] == 3'b101) m_rate[addr[4:0]] = merge(m_rate[addr[4:0]], din, we);
            if (cs && addr == 8'hC0) m_gate = merge(m_gate, din, we);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (busy !== lvl) begin
            n_err++;
            $display("FAIL timeout_%s: busy=%b, expected %b within %0d cycles", tag, busy, lvl, budget);
        end
    endtask

    task automatic sweep();
        wait_busy(1'b1, 600, "sweep_start");
        wait_busy(1'b0, 2000, "sweep_end");
    endtask

    // Config writes are only issued between sweeps
    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        @(posedge clk); #1;
        if (a[7]) wait_busy(1'b0, 2000, "cfg_idle");
        cs = 1'b1; addr = a; din = d; we = w;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        int k;
        logic [7:0] a;
        for (int i = 0; i < 32; i++) begin
            m_peak[i] = '0; m_rate[i] = '0; last_din[i] = '0;
            v_wr_cnt[i] = 0; v_wr_cyc[i] = 0;
        end
        cyc = 0; sweep_start = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Fill the uncleared tables so every voice has defined contents
        for (int i = 0; i < 32; i++) begin
            cpu_wr(8'h80 + 8'(i), $urandom, 4'hF);
            cpu_wr(8'hA0 + 8'(i), $urandom, 4'hF);
        end

        // Passthrough
        cpu_wr(8'h05, 32'h0001_0000, 4'hF);
        check("pt_lit_cs", {31'b0, snd_cs}, 32'h1);
        check("pt_lit_addr", {24'b0, snd_addr}, 32'h05);
        check("pt_lit_din", snd_din, 32'h0001_0000);
        check("pt_lit_we", {28'b0, snd_we}, 32'hF);

        // Attack on voice 0, then release
        cpu_wr(8'h80, 32'h4000_7FFF, 4'hF);
        cpu_wr(8'hA0, 32'h8000_4000, 4'hF);
        cpu_wr(8'hC0, 32'h0000_0001, 4'hF);
        sweep(); check("atk_1", last_din[0], 32'h1000_1FFF);
        sweep(); check("atk_2", last_din[0], 32'h2000_3FFF);
        sweep(); check("atk_3", last_din[0], 32'h3000_5FFF);
        sweep(); check("atk_sus", last_din[0], 32'h4000_7FFF);
        cpu_wr(8'hC0, 32'h0000_0000, 4'hF);
        sweep(); check("rel_1", last_din[0], 32'h1FFF_3FFF);
        sweep(); check("rel_idle", last_din[0], 32'h0000_0000);

        // Zero rates on voice 1
        cpu_wr(8'h81, 32'h8000_1234, 4'hF);
        cpu_wr(8'hA1, 32'h0000_0000, 4'hF);
        cpu_wr(8'hC0, 32'h0000_0002, 4'hF);
        sweep(); check("zr_peak", last_din[1], 32'h8000_1234);
        cpu_wr(8'hC0, 32'h0000_0000, 4'hF);
        sweep(); check("zr_off", last_din[1], 32'h0000_0000);

        // Contention during voice 3 ISSUE
        cpu_wr(8'h83, 32'h2222_5555, 4'hF);
        cpu_wr(8'hA3, 32'h0000_0000, 4'hF);
        cpu_wr(8'hC0, 32'h0000_0008, 4'hF);
        wait_busy(1'b1, 600, "cont_start");
        repeat (10) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            cs = 1'b1; addr = 8'(i); we = 4'hF; din = $urandom;
            @(posedge clk); #1;
        end
        cs = 1'b0;
        wait_busy(1'b0, 600, "cont_end");
        check("cont_v3_once", 32'(v_wr_cnt[3]), 32'd1);
        check("cont_v3_cycle", 32'(v_wr_cyc[3]), 32'd21);
        check("cont_v3_din", last_din[3], 32'h2222_5555);
        n = 0;
        for (int i = 0; i < 32; i++) if (v_wr_cnt[i] != 1) n++;
        check("cont_all_once", 32'(n), 32'd0);

        // Randomised traffic
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            cs = 1'b0;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                cs = 1'b1; addr = {1'b0, 7'($urandom)}; we = 4'($urandom); din = $urandom;
            end else if (r < 5 && busy == 1'b0) begin
                k = $urandom_range(0, 9);
                if (k < 4)      a = 8'h80 + 8'($urandom_range(0, 31));
                else if (k < 8) a = 8'hA0 + 8'($urandom_range(0, 31));
                else if (k < 9) a = 8'hC0;
                else            a = 8'hC1 + 8'($urandom_range(0, 62));
                cs = 1'b1; addr = a; we = 4'($urandom); din = $urandom;
            end
        end
        @(posedge clk); #1;
        cs = 1'b0;

        // Overrun by starving the engine
        wait_busy(1'b0, 2000, "ovr_idle");
        wait_busy(1'b1, 600, "ovr_start");
        for (int i = 0; i < 300; i++) begin
            cs = 1'b1; addr = 8'h10; we = 4'hF; din = $urandom;
            @(posedge clk); #1;
        end
        cs = 1'b0;
        check("ovr_set", {31'b0, overrun}, 32'h1);
        wait_busy(1'b0, 600, "ovr_end");
        check("ovr_sticky", {31'b0, overrun}, 32'h1);

        // Reset mid-sweep
        wait_busy(1'b1, 600, "rst_start");
        repeat (20) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_lit_busy", {31'b0, busy}, 32'h0);
        check("rst_lit_ovr", {31'b0, overrun}, 32'h0);
        check("rst_lit_cs", {31'b0, snd_cs}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        sweep();
        check("post_rst_v3", last_din[3], 32'h0);
        check("post_rst_v1", last_din[1], 32'h0);
        check("post_rst_ovr", {31'b0, overrun}, 32'h0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
